// File: rtl/apb_pkg.sv
// Shared APB definitions for the proc_int_thread requester and mem_int_thread completer.
// Holds the bus width defaults, the timeout default and the transfer-phase state type.
package apb_pkg;

  localparam int ADDR_W_DEF         = 16;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/proc_int_thread.sv
// APB requester: turns Pep9 processor addr/dataIn/we changes into APB SETUP/ACCESS transfers.
// Optional feature APB_TIMEOUT_EN aborts an ACCESS phase that waits TIMEOUT_CYCLES cycles.
module proc_int_thread
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              sysclk,
  input  logic              PResetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              we,
  output logic [DATA_W-1:0] dataOut,
  output logic              PClk,
  output logic [ADDR_W-1:0] PAddr,
  output logic              PSelx,
  output logic              PEnable,
  output logic              PWrite,
  output logic [DATA_W-1:0] PWData,
  input  logic              PReady,
  input  logic [DATA_W-1:0] PRData
);

  apb_state_e        state, state_n;
  logic              first;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic              last_we;
  logic              pending;
  logic              finish;
  logic              abort;
  logic              timeout;

  assign PClk = sysclk;

  // A request is pending until the exact {addr, we, dataIn} triple has completed once.
  assign pending = first || (addr != last_addr) || (we != last_we) || (dataIn != last_data);

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge sysclk or negedge PResetn) begin
    if (!PResetn)                       to_cnt <= '0;
    else if (state == ACCESS && !PReady) to_cnt <= to_cnt + 1'b1;
    else                                to_cnt <= '0;
  end

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sysclk or negedge PResetn) begin
    if (!PResetn) state <= IDLE;
    else          state <= state_n;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE:   if (pending) state_n = SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        if (PReady) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus-facing registers; the address phase values double as the in-flight triple.
  always_ff @(posedge sysclk or negedge PResetn) begin
    if (!PResetn) begin
      PSelx     <= 1'b0;
      PEnable   <= 1'b0;
      PWrite    <= 1'b0;
      PAddr     <= '0;
      PWData    <= '0;
      dataOut   <= '0;
      first     <= 1'b1;
      last_addr <= '0;
      last_data <= '0;
      last_we   <= 1'b0;
    end else begin
      PSelx   <= (state_n != IDLE);
      PEnable <= (state_n == ACCESS);
      if (state == IDLE && pending) begin
        PAddr  <= addr;
        PWrite <= we;
        PWData <= dataIn;
      end
      if (finish) begin
        last_addr <= PAddr;
        last_we   <= PWrite;
        last_data <= PWData;
        first     <= 1'b0;
        if (!PWrite) dataOut <= abort ? '1 : PRData;
      end
    end
  end

endmodule

// File: tb/tb_proc_int_thread.sv
// Directed bench for proc_int_thread with a small behavioural APB completer.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the abort path.
module tb_proc_int_thread;

  logic        sysclk = 1'b0;
  logic        PResetn;
  logic [15:0] addr;
  logic [7:0]  dataIn;
  logic        we;
  logic [7:0]  dataOut;
  logic        PClk;
  logic [15:0] PAddr;
  logic        PSelx;
  logic        PEnable;
  logic        PWrite;
  logic [7:0]  PWData;
  logic        PReady;
  logic [7:0]  PRData;

  int checks = 0;
  int errors = 0;
  int setups = 0;
  int acc_cnt;
  int wait_states = 0;
  bit stall = 1'b0;

  always #5 sysclk = ~sysclk;

  proc_int_thread dut (
    .sysclk (sysclk),
    .PResetn(PResetn),
    .addr   (addr),
    .dataIn (dataIn),
    .we     (we),
    .dataOut(dataOut),
    .PClk   (PClk),
    .PAddr  (PAddr),
    .PSelx  (PSelx),
    .PEnable(PEnable),
    .PWrite (PWrite),
    .PWData (PWData),
    .PReady (PReady),
    .PRData (PRData)
  );

  // Completer: ready after wait_states ACCESS cycles unless stalled.
  assign PReady = PSelx && PEnable && !stall && (acc_cnt >= wait_states);

  always @(posedge sysclk or negedge PResetn) begin
    if (!PResetn)                      acc_cnt <= 0;
    else if (PSelx && PEnable && !PReady) acc_cnt <= acc_cnt + 1;
    else                               acc_cnt <= 0;
  end

  always @(posedge sysclk) begin
    if (PResetn && PSelx && !PEnable) setups++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic run_to_idle(input string tag, input int max, output int en);
    int n;
    n  = 0;
    en = 0;
    while (PSelx && n < max) begin
      if (PEnable) en++;
      cyc(1);
      n++;
    end
    check({tag, "_idle"}, {31'd0, PSelx}, 32'd0);
  endtask

  initial begin
    int en;
    int bad_addr;
    int early;

    PResetn = 1'b0;
    addr    = 16'h0010;
    we      = 1'b1;
    dataIn  = 8'hA5;
    PRData  = 8'h00;
    cyc(2);
    check("rst_psel",    {31'd0, PSelx},   32'd0);
    check("rst_penable", {31'd0, PEnable}, 32'd0);
    check("rst_dataout", {24'd0, dataOut}, 32'd0);
    check("rst_paddr",   {16'd0, PAddr},   32'd0);
    PResetn = 1'b1;

    // Zero-wait write
    cyc(1);
    check("wr_setup_psel", {31'd0, PSelx},   32'd1);
    check("wr_setup_pen",  {31'd0, PEnable}, 32'd0);
    check("wr_paddr",      {16'd0, PAddr},   32'h0010);
    check("wr_pwrite",     {31'd0, PWrite},  32'd1);
    check("wr_pwdata",     {24'd0, PWData},  32'h00A5);
    cyc(1);
    check("wr_access_pen", {31'd0, PEnable}, 32'd1);
    cyc(1);
    check("wr_done_psel",  {31'd0, PSelx},   32'd0);
    check("wr_done_pen",   {31'd0, PEnable}, 32'd0);
    cyc(8);
    check("wr_no_repeat",  setups, 1);
    check("wr_dataout_held", {24'd0, dataOut}, 32'd0);

    // Zero-wait read of the same address
    we     = 1'b0;
    PRData = 8'hA5;
    cyc(1);
    check("rd_setup_psel", {31'd0, PSelx},  32'd1);
    check("rd_pwrite",     {31'd0, PWrite}, 32'd0);
    run_to_idle("rd", 10, en);
    check("rd_en_cycles", en, 1);
    check("rd_dataout",   {24'd0, dataOut}, 32'h00A5);
    cyc(5);
    check("rd_no_repeat", setups, 2);

    // Read with three wait states
    addr        = 16'h0020;
    wait_states = 3;
    PRData      = 8'h3C;
    cyc(1);
    check("ws_setup_pen", {31'd0, PEnable}, 32'd0);
    en = 0; bad_addr = 0; early = 0;
    for (int n = 0; n < 20 && PSelx; n++) begin
      if (PEnable) begin
        en++;
        if (PAddr != 16'h0020) bad_addr++;
        if (dataOut != 8'hA5)  early++;
      end
      cyc(1);
    end
    check("ws_en_cycles",   en, 4);
    check("ws_paddr_stable", bad_addr, 0);
    check("ws_dataout_early", early, 0);
    check("ws_dataout",      {24'd0, dataOut}, 32'h003C);
    check("ws_idle",         {31'd0, PSelx},   32'd0);

    // Address change during ACCESS is deferred to the next transfer
    we          = 1'b1;
    dataIn      = 8'h11;
    wait_states = 2;
    cyc(2);
    check("chg_in_access", {31'd0, PEnable}, 32'd1);
    addr = 16'h0030;
    bad_addr = 0;
    for (int n = 0; n < 20 && PSelx; n++) begin
      if (PAddr != 16'h0020) bad_addr++;
      cyc(1);
    end
    check("chg_cur_paddr", bad_addr, 0);
    check("chg_cur_idle",  {31'd0, PSelx}, 32'd0);
    cyc(1);
    check("chg_next_psel",  {31'd0, PSelx},   32'd1);
    check("chg_next_pen",   {31'd0, PEnable}, 32'd0);
    check("chg_next_paddr", {16'd0, PAddr},   32'h0030);
    check("chg_next_pwdata", {24'd0, PWData}, 32'h0011);
    run_to_idle("chg_next", 20, en);
    check("chg_dataout_held", {24'd0, dataOut}, 32'h003C);

    // Reset asserted mid-ACCESS
    addr        = 16'h0050;
    we          = 1'b0;
    wait_states = 0;
    stall       = 1'b1;
    cyc(2);
    check("rst_mid_access", {31'd0, PEnable}, 32'd1);
    cyc(2);
    PResetn = 1'b0;
    #1;
    check("rst_mid_psel",    {31'd0, PSelx},   32'd0);
    check("rst_mid_pen",     {31'd0, PEnable}, 32'd0);
    check("rst_mid_dataout", {24'd0, dataOut}, 32'd0);
    cyc(1);
    PResetn = 1'b1;
    stall   = 1'b0;
    PRData  = 8'h77;
    cyc(1);
    check("rst_reissue_psel",  {31'd0, PSelx}, 32'd1);
    check("rst_reissue_paddr", {16'd0, PAddr}, 32'h0050);
    run_to_idle("rst_reissue", 10, en);
    check("rst_reissue_data", {24'd0, dataOut}, 32'h0077);

    // Completer that never becomes ready
    addr  = 16'h0060;
    stall = 1'b1;
    cyc(1);
    check("to_setup", {31'd0, PSelx}, 32'd1);
`ifdef APB_TIMEOUT_EN
    run_to_idle("to", 40, en);
    check("to_en_cycles", en, 16);
    check("to_dataout",   {24'd0, dataOut}, 32'h00FF);
    check("to_pen",       {31'd0, PEnable}, 32'd0);
    stall = 1'b0;
    cyc(5);
    check("to_no_retry", {31'd0, PSelx}, 32'd0);
`else
    cyc(40);
    check("nto_still_access", {31'd0, PEnable}, 32'd1);
    check("nto_dataout_held", {24'd0, dataOut}, 32'h0077);
    stall = 1'b0;
    run_to_idle("nto", 10, en);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
